l2_bank_scrub_arbiter: RTL and testbench
========================================

Name: l2_bank_scrub_arbiter

Overview:
- Sits between one L2 TCDM slave port and its ECC SRAM bank.
- Shares the single bank port between TCDM traffic and a background ECC scrubber.
- The scrubber walks every word of the bank, reads it, and writes corrected data back on a single-bit error. It counts scrubbed, corrected and uncorrectable words.
- TCDM traffic has priority. A starvation limit guarantees scrub progress.

Parameters:
- BANK_SIZE, 8192, bank depth in 32-bit words; must be a power of two.
- ADDR_W, $clog2(BANK_SIZE), word-address width (derived).
- STARVE_LIMIT, 16, cycles a pending scrub read may wait before it preempts TCDM; must be ≥1.
- CNT_W, 16, width of the status counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- scrub_en_i  in  1  enables scrubbing.
- scrub_interval_i  in  16  idle cycles between scrub reads.
- tcdm_req_i  in  1  TCDM request.
- tcdm_gnt_o  out  1  TCDM grant.
- tcdm_wen_i  in  1  1=read, 0=write.
- tcdm_add_i  in  ADDR_W  word address.
- tcdm_wdata_i  in  32  write data.
- tcdm_be_i  in  4  byte enables.
- tcdm_rvalid_o  out  1  response valid, one cycle after grant.
- tcdm_rdata_o  out  32  read data.
- bank_req_o  out  1  bank access.
- bank_we_o  out  1  1=write.
- bank_addr_o  out  ADDR_W  bank word address.
- bank_wdata_o  out  32  bank write data.
- bank_be_o  out  4  bank byte enables.
- bank_rdata_i  in  32  corrected read data, valid one cycle after a read.
- bank_err_single_i  in  1  corrected single error on bank_rdata_i.
- bank_err_multi_i  in  1  uncorrectable error on bank_rdata_i.
- scrub_addr_o  out  ADDR_W  next scrub address.
- scrub_cnt_o  out  CNT_W  completed scrub reads, saturating.
- corr_cnt_o  out  CNT_W  single errors corrected, saturating.
- uncorr_cnt_o  out  CNT_W  multi-bit errors found, saturating.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - State=IDLE; scrub pointer, interval counter, starve counter and all status counters = 0.
  - tcdm_rvalid_o=0.
  - A reset mid-scrub aborts without writeback.
- Default bank mux (TCDM path):
  - bank_req_o=tcdm_req_i & tcdm_gnt_o.
  - bank_we_o=~tcdm_wen_i.
  - addr, wdata and be pass through from the TCDM port.
  - tcdm_gnt_o is combinational and equals 1 unless the scrubber owns the bank this cycle.
- tcdm_rvalid_o is registered as tcdm_req_i & tcdm_gnt_o. It is asserted for reads and writes alike.
- tcdm_rdata_o=bank_rdata_i.
- FSM:
  - IDLE:
    - Stay while scrub_en_i=0.
    - Otherwise load the interval counter with scrub_interval_i and go to WAIT.
    - If scrub_interval_i=0, go directly to PEND.
  - WAIT:
    - Decrement each cycle; at count 1 go to PEND.
    - scrub_en_i=0 → IDLE.
  - PEND:
    - If tcdm_req_i=0, issue the scrub read this cycle: bank_req_o=1, we=0, addr=scrub pointer, be=4'hF. Go to RESP.
    - If tcdm_req_i=1, TCDM is granted and the starve counter increments.
    - When the starve counter = STARVE_LIMIT, force tcdm_gnt_o=0, issue the scrub read and go to RESP.
    - The starve counter clears on entering RESP.
    - scrub_en_i=0 → IDLE without a read.
  - RESP (bank_rdata_i valid):
    - The scrub pointer increments, wrapping BANK_SIZE-1 → 0.
    - scrub_cnt increments.
    - If bank_err_single_i=1 (and bank_err_multi_i=0): this cycle drive the writeback. bank_req_o=1, we=1, addr=previous pointer, wdata=bank_rdata_i, be=4'hF. Force tcdm_gnt_o=0 and increment corr_cnt.
    - Else if bank_err_multi_i=1: increment uncorr_cnt, no writeback, TCDM may be granted.
    - Else TCDM may be granted.
    - Next state: IDLE-path reload. Go to WAIT (or PEND if the interval is 0) when scrub_en_i=1, else IDLE.
    - RESP always completes even if scrub_en_i drops.
- No TCDM write can hit the scrubbed word between read and writeback: the read cycle and the writeback cycle both own the bank.
- tcdm_rvalid_o is never asserted in the cycle after a scrub read; the bank response in that cycle belongs to the scrubber.
- Counters saturate at 2^CNT_W-1 and never wrap.
- scrub_addr_o shows the scrub pointer.

Test Plan:
- Idle bank, en=1, interval=3, no errors → scrub read issued at cycle 4 after enable. The pointer 0→1, scrub_cnt=1 and no bank write occur. Repeat BANK_SIZE times → pointer wraps to 0 and scrub_cnt=8192.
- Continuous tcdm_req_i=1 reads, interval=0, STARVE_LIMIT=16 → TCDM is granted for 16 cycles after PEND entry, then tcdm_gnt_o=0 for exactly one cycle. tcdm_rvalid_o=0 the following cycle, while TCDM is granted again.
- Scrub read at addr 5 returns 0xDEADBEEF with err_single=1 → next cycle shows bank_we_o=1, addr=5, wdata=0xDEADBEEF, be=F, tcdm_gnt_o=0 and corr_cnt=1.
- Scrub read returns err_multi=1 → no write, uncorr_cnt=1 and TCDM is granted in the RESP cycle.
- en dropped during WAIT → IDLE next cycle with no read. en dropped in RESP with err_single → writeback still occurs, then IDLE.
- rst_i asserted during RESP with err_single → no writeback; all counters=0, pointer=0, tcdm_rvalid_o=0 the next cycle. Counter saturation with CNT_W=4 → scrub_cnt holds at 15.

Source files
------------

// File: rtl/l2_bank_scrub_arbiter.sv
// l2_bank_scrub_arbiter
//
// Purpose: shares one ECC SRAM bank port between an L2 TCDM slave port and a
// background scrubber. The scrubber walks the bank word by word. It reads each
// word and writes the corrected data back when the bank reports a single-bit
// error. TCDM traffic normally wins arbitration. A starvation counter lets a
// pending scrub read take the bank after STARVE_LIMIT lost cycles.
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   scrub_en_i                 scrubber enable
//   scrub_interval_i[15:0]     idle cycles between scrub reads (0 = back-to-back)
//   tcdm_req_i/gnt_o           TCDM handshake (gnt is combinational)
//   tcdm_wen_i                 1=read, 0=write
//   tcdm_add_i/wdata_i/be_i    TCDM address, write data, byte enables
//   tcdm_rvalid_o/rdata_o      TCDM response, one cycle after grant
//   bank_req_o/we_o/addr_o/wdata_o/be_o   bank request side
//   bank_rdata_i               corrected bank read data (one cycle after read)
//   bank_err_single_i/multi_i  ECC status accompanying bank_rdata_i
//   scrub_addr_o               next scrub word address
//   scrub_cnt_o/corr_cnt_o/uncorr_cnt_o   saturating status counters
module l2_bank_scrub_arbiter #(
  parameter int BANK_SIZE    = 8192,
  parameter int ADDR_W       = $clog2(BANK_SIZE),
  parameter int STARVE_LIMIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              scrub_en_i,
  input  logic [15:0]       scrub_interval_i,
  input  logic              tcdm_req_i,
  output logic              tcdm_gnt_o,
  input  logic              tcdm_wen_i,
  input  logic [ADDR_W-1:0] tcdm_add_i,
  input  logic [31:0]       tcdm_wdata_i,
  input  logic [3:0]        tcdm_be_i,
  output logic              tcdm_rvalid_o,
  output logic [31:0]       tcdm_rdata_o,
  output logic              bank_req_o,
  output logic              bank_we_o,
  output logic [ADDR_W-1:0] bank_addr_o,
  output logic [31:0]       bank_wdata_o,
  output logic [3:0]        bank_be_o,
  input  logic [31:0]       bank_rdata_i,
  input  logic              bank_err_single_i,
  input  logic              bank_err_multi_i,
  output logic [ADDR_W-1:0] scrub_addr_o,
  output logic [CNT_W-1:0]  scrub_cnt_o,
  output logic [CNT_W-1:0]  corr_cnt_o,
  output logic [CNT_W-1:0]  uncorr_cnt_o
);

  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_PEND = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [15:0]       interval_r;
  logic [STV_W-1:0]  starve_r;
  logic [ADDR_W-1:0] ptr_r;
  logic [CNT_W-1:0]  scrub_cnt_r, corr_cnt_r, uncorr_cnt_r;
  logic              rvalid_r;

  logic              starve_hit_s;
  logic              scrub_rd_s;
  logic              wb_s;
  logic              single_s;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign starve_hit_s = (starve_r == STV_W'(STARVE_LIMIT));
  assign single_s     = bank_err_single_i & ~bank_err_multi_i;

  // Scrubber bank ownership. Reset suppresses both accesses, so a reset landing
  // in RESP aborts the writeback rather than racing it.
  assign scrub_rd_s = (state_r == ST_PEND) & scrub_en_i & ~rst_i &
                      (~tcdm_req_i | starve_hit_s);
  assign wb_s       = (state_r == ST_RESP) & single_s & ~rst_i;
  assign tcdm_gnt_o = ~(scrub_rd_s | wb_s);

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; RESP always finishes its cycle regardless of enable.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_RESP: begin
        if (scrub_en_i) begin
          state_s = (scrub_interval_i == 16'd0) ? ST_PEND : ST_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!scrub_en_i) begin
          state_s = ST_IDLE;
        end else if (interval_r <= 16'd1) begin
          state_s = ST_PEND;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_PEND: begin
        if (!scrub_en_i) begin
          state_s = ST_IDLE;
        end else if (scrub_rd_s) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_PEND;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM outputs: bank mux between the TCDM path, scrub read and writeback.
  always_comb begin
    bank_req_o   = tcdm_req_i & tcdm_gnt_o;
    bank_we_o    = ~tcdm_wen_i;
    bank_addr_o  = tcdm_add_i;
    bank_wdata_o = tcdm_wdata_i;
    bank_be_o    = tcdm_be_i;
    if (scrub_rd_s) begin
      bank_req_o   = 1'b1;
      bank_we_o    = 1'b0;
      bank_addr_o  = ptr_r;
      bank_wdata_o = 32'd0;
      bank_be_o    = 4'hF;
    end else if (wb_s) begin
      // ptr_r still holds the address just read; it advances at the end of RESP.
      bank_req_o   = 1'b1;
      bank_we_o    = 1'b1;
      bank_addr_o  = ptr_r;
      bank_wdata_o = bank_rdata_i;
      bank_be_o    = 4'hF;
    end else begin
      bank_req_o   = tcdm_req_i & tcdm_gnt_o;
      bank_we_o    = ~tcdm_wen_i;
      bank_addr_o  = tcdm_add_i;
      bank_wdata_o = tcdm_wdata_i;
      bank_be_o    = tcdm_be_i;
    end
  end

  // Scrub datapath: interval/starve counters, pointer, status counters, rvalid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      interval_r   <= 16'd0;
      starve_r     <= '0;
      ptr_r        <= '0;
      scrub_cnt_r  <= '0;
      corr_cnt_r   <= '0;
      uncorr_cnt_r <= '0;
      rvalid_r     <= 1'b0;
    end else begin
      rvalid_r <= tcdm_req_i & tcdm_gnt_o;

      if ((state_r == ST_IDLE || state_r == ST_RESP) && scrub_en_i) begin
        interval_r <= scrub_interval_i;
      end else if (state_r == ST_WAIT) begin
        interval_r <= interval_r - 16'd1;
      end else begin
        interval_r <= interval_r;
      end

      // Only a PEND cycle lost to TCDM advances the starve count.
      if (state_r == ST_PEND && scrub_en_i && !scrub_rd_s) begin
        starve_r <= starve_r + STV_W'(1);
      end else begin
        starve_r <= '0;
      end

      if (state_r == ST_RESP) begin
        // BANK_SIZE is a power of two, so the natural wrap returns to 0.
        ptr_r       <= ptr_r + ADDR_W'(1);
        scrub_cnt_r <= sat_inc(scrub_cnt_r);
        if (single_s) begin
          corr_cnt_r <= sat_inc(corr_cnt_r);
        end else begin
          corr_cnt_r <= corr_cnt_r;
        end
        if (bank_err_multi_i) begin
          uncorr_cnt_r <= sat_inc(uncorr_cnt_r);
        end else begin
          uncorr_cnt_r <= uncorr_cnt_r;
        end
      end else begin
        ptr_r        <= ptr_r;
        scrub_cnt_r  <= scrub_cnt_r;
        corr_cnt_r   <= corr_cnt_r;
        uncorr_cnt_r <= uncorr_cnt_r;
      end
    end
  end

  assign tcdm_rvalid_o = rvalid_r;
  assign tcdm_rdata_o  = bank_rdata_i;
  assign scrub_addr_o  = ptr_r;
  assign scrub_cnt_o   = scrub_cnt_r;
  assign corr_cnt_o    = corr_cnt_r;
  assign uncorr_cnt_o  = uncorr_cnt_r;

endmodule

// File: tb/tb_l2_bank_scrub_arbiter.sv
// Directed bench for l2_bank_scrub_arbiter: a vector table for the TCDM
// pass-through path plus hand-written scrub sequences. A second instance with
// CNT_W=4 shares the stimulus to show counter saturation.
module tb_l2_bank_scrub_arbiter;

  localparam int AW = 13;

  logic          clk;
  logic          rst_i;
  logic          scrub_en_i;
  logic [15:0]   scrub_interval_i;
  logic          tcdm_req_i;
  logic          tcdm_wen_i;
  logic [AW-1:0] tcdm_add_i;
  logic [31:0]   tcdm_wdata_i;
  logic [3:0]    tcdm_be_i;
  logic [31:0]   bank_rdata_i;
  logic          bank_err_single_i;
  logic          bank_err_multi_i;

  logic          tcdm_gnt_o, tcdm_rvalid_o;
  logic [31:0]   tcdm_rdata_o;
  logic          bank_req_o, bank_we_o;
  logic [AW-1:0] bank_addr_o;
  logic [31:0]   bank_wdata_o;
  logic [3:0]    bank_be_o;
  logic [AW-1:0] scrub_addr_o;
  logic [15:0]   scrub_cnt_o, corr_cnt_o, uncorr_cnt_o;

  logic          s_gnt, s_rvalid, s_breq, s_bwe;
  logic [31:0]   s_rdata, s_bwdata;
  logic [AW-1:0] s_baddr, s_saddr;
  logic [3:0]    s_bbe;
  logic [3:0]    s_scnt, s_ccnt, s_ucnt;

  l2_bank_scrub_arbiter dut (
    .clk_i(clk), .rst_i(rst_i), .scrub_en_i(scrub_en_i),
    .scrub_interval_i(scrub_interval_i),
    .tcdm_req_i(tcdm_req_i), .tcdm_gnt_o(tcdm_gnt_o), .tcdm_wen_i(tcdm_wen_i),
    .tcdm_add_i(tcdm_add_i), .tcdm_wdata_i(tcdm_wdata_i), .tcdm_be_i(tcdm_be_i),
    .tcdm_rvalid_o(tcdm_rvalid_o), .tcdm_rdata_o(tcdm_rdata_o),
    .bank_req_o(bank_req_o), .bank_we_o(bank_we_o), .bank_addr_o(bank_addr_o),
    .bank_wdata_o(bank_wdata_o), .bank_be_o(bank_be_o),
    .bank_rdata_i(bank_rdata_i), .bank_err_single_i(bank_err_single_i),
    .bank_err_multi_i(bank_err_multi_i), .scrub_addr_o(scrub_addr_o),
    .scrub_cnt_o(scrub_cnt_o), .corr_cnt_o(corr_cnt_o), .uncorr_cnt_o(uncorr_cnt_o)
  );

  l2_bank_scrub_arbiter #(.CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_i(rst_i), .scrub_en_i(scrub_en_i),
    .scrub_interval_i(scrub_interval_i),
    .tcdm_req_i(tcdm_req_i), .tcdm_gnt_o(s_gnt), .tcdm_wen_i(tcdm_wen_i),
    .tcdm_add_i(tcdm_add_i), .tcdm_wdata_i(tcdm_wdata_i), .tcdm_be_i(tcdm_be_i),
    .tcdm_rvalid_o(s_rvalid), .tcdm_rdata_o(s_rdata),
    .bank_req_o(s_breq), .bank_we_o(s_bwe), .bank_addr_o(s_baddr),
    .bank_wdata_o(s_bwdata), .bank_be_o(s_bbe),
    .bank_rdata_i(bank_rdata_i), .bank_err_single_i(bank_err_single_i),
    .bank_err_multi_i(bank_err_multi_i), .scrub_addr_o(s_saddr),
    .scrub_cnt_o(s_scnt), .corr_cnt_o(s_ccnt), .uncorr_cnt_o(s_ucnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic          req;
    logic          wen;
    logic [AW-1:0] add;
    logic [31:0]   wdata;
    logic [3:0]    be;
    logic [31:0]   rdata;
    logic          exp_gnt;
    logic          exp_breq;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [31:0]   exp_wdata;
    logic [3:0]    exp_be;
    logic [31:0]   exp_rdata;
    logic          exp_rvalid;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_ptr, reads, addr_err, grants, busy;

  initial begin
    rst_i = 1'b1; scrub_en_i = 1'b0; scrub_interval_i = 16'd0;
    tcdm_req_i = 1'b0; tcdm_wen_i = 1'b1; tcdm_add_i = '0;
    tcdm_wdata_i = 32'd0; tcdm_be_i = 4'd0; bank_rdata_i = 32'd0;
    bank_err_single_i = 1'b0; bank_err_multi_i = 1'b0;

    //            req   wen   add        wdata          be    rdata          gnt   breq  we    addr       wdata          be    rdata          rvalid
    vecs[0] = '{1'b1, 1'b1, 13'h0010, 32'h11111111, 4'hF, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b0, 13'h0010, 32'h11111111, 4'hF, 32'hA5A5A5A5, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 13'h1FFF, 32'hCAFEF00D, 4'h3, 32'h00000000, 1'b1, 1'b1, 1'b1, 13'h1FFF, 32'hCAFEF00D, 4'h3, 32'h00000000, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 13'h00AA, 32'h00000000, 4'h0, 32'h12345678, 1'b1, 1'b0, 1'b0, 13'h00AA, 32'h00000000, 4'h0, 32'h12345678, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 13'h0000, 32'hFFFFFFFF, 4'h8, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 13'h0000, 32'hFFFFFFFF, 4'h8, 32'hFFFFFFFF, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 13'h0123, 32'h00000005, 4'h1, 32'h00000001, 1'b1, 1'b0, 1'b1, 13'h0123, 32'h00000005, 4'h1, 32'h00000001, 1'b1};

    // Reset state
    repeat (3) tick();
    rst_i = 1'b0;
    #1;
    chk("rst_scrub_addr", 32'(scrub_addr_o), 32'd0);
    chk("rst_scrub_cnt", 32'(scrub_cnt_o), 32'd0);
    chk("rst_corr_cnt", 32'(corr_cnt_o), 32'd0);
    chk("rst_uncorr_cnt", 32'(uncorr_cnt_o), 32'd0);
    chk("rst_rvalid", 32'(tcdm_rvalid_o), 32'd0);
    chk("rst_gnt", 32'(tcdm_gnt_o), 32'd1);
    chk("rst_bank_req", 32'(bank_req_o), 32'd0);

    // TCDM pass-through vectors with the scrubber disabled
    for (int i = 0; i < 5; i++) begin
      tick();
      tcdm_req_i = vecs[i].req; tcdm_wen_i = vecs[i].wen; tcdm_add_i = vecs[i].add;
      tcdm_wdata_i = vecs[i].wdata; tcdm_be_i = vecs[i].be; bank_rdata_i = vecs[i].rdata;
      #1;
      chk($sformatf("vec%0d_gnt", i), 32'(tcdm_gnt_o), 32'(vecs[i].exp_gnt));
      chk($sformatf("vec%0d_breq", i), 32'(bank_req_o), 32'(vecs[i].exp_breq));
      chk($sformatf("vec%0d_we", i), 32'(bank_we_o), 32'(vecs[i].exp_we));
      chk($sformatf("vec%0d_addr", i), 32'(bank_addr_o), 32'(vecs[i].exp_addr));
      chk($sformatf("vec%0d_wdata", i), bank_wdata_o, vecs[i].exp_wdata);
      chk($sformatf("vec%0d_be", i), 32'(bank_be_o), 32'(vecs[i].exp_be));
      chk($sformatf("vec%0d_rdata", i), tcdm_rdata_o, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_rvalid", i), 32'(tcdm_rvalid_o), 32'(vecs[i].exp_rvalid));
    end

    // Interval 3: read issued 4 cycles after enable, then drop enable in WAIT
    tick();
    tcdm_req_i = 1'b0; tcdm_wen_i = 1'b1; tcdm_add_i = '0; tcdm_wdata_i = 32'd0;
    tcdm_be_i = 4'd0; bank_rdata_i = 32'h0; scrub_en_i = 1'b1; scrub_interval_i = 16'd3;
    #1;
    chk("idle_no_read", 32'(bank_req_o), 32'd0);
    busy = 0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (bank_req_o) busy++;
    end
    chk("wait_no_read", 32'(busy), 32'd0);
    tick();
    chk("rd4_req", 32'(bank_req_o), 32'd1);
    chk("rd4_we", 32'(bank_we_o), 32'd0);
    chk("rd4_addr", 32'(bank_addr_o), 32'd0);
    chk("rd4_be", 32'(bank_be_o), 32'hF);
    chk("rd4_gnt", 32'(tcdm_gnt_o), 32'd0);
    tick();
    chk("resp_clean_no_write", 32'(bank_req_o), 32'd0);
    chk("resp_clean_gnt", 32'(tcdm_gnt_o), 32'd1);
    tick();
    scrub_en_i = 1'b0;
    #1;
    chk("ptr_after_1", 32'(scrub_addr_o), 32'd1);
    chk("cnt_after_1", 32'(scrub_cnt_o), 32'd1);
    busy = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bank_req_o) busy++;
    end
    chk("en_drop_wait_idle", 32'(busy), 32'd0);

    // Back-to-back scrubs until the pointer wraps
    tick();
    scrub_en_i = 1'b1; scrub_interval_i = 16'd0;
    exp_ptr = 1; reads = 0; addr_err = 0;
    for (int c = 0; c < 20000 && reads < 8191; c++) begin
      tick();
      if (bank_req_o && !bank_we_o) begin
        if (32'(bank_addr_o) != exp_ptr) addr_err++;
        exp_ptr = (exp_ptr + 1) % 8192;
        reads++;
      end
    end
    chk("wrap_reads_in_budget", 32'(reads), 32'd8191);
    chk("wrap_addr_seq_errors", 32'(addr_err), 32'd0);
    tick();
    scrub_en_i = 1'b0;
    tick();
    chk("wrap_ptr", 32'(scrub_addr_o), 32'd0);
    chk("wrap_scrub_cnt", 32'(scrub_cnt_o), 32'd8192);
    chk("sat_scrub_cnt", 32'(s_scnt), 32'd15);
    chk("sat_ptr", 32'(s_saddr), 32'd0);

    // Starvation: continuous TCDM reads, interval 0
    tick();
    scrub_en_i = 1'b1; tcdm_req_i = 1'b1; tcdm_wen_i = 1'b1; tcdm_add_i = 13'h0042;
    #1;
    chk("starve_idle_gnt", 32'(tcdm_gnt_o), 32'd1);
    grants = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (tcdm_gnt_o && bank_req_o && bank_addr_o == 13'h0042) grants++;
    end
    chk("starve_grants", 32'(grants), 32'd16);
    tick();
    chk("starve_gnt_low", 32'(tcdm_gnt_o), 32'd0);
    chk("starve_rd_req", 32'(bank_req_o), 32'd1);
    chk("starve_rd_we", 32'(bank_we_o), 32'd0);
    chk("starve_rd_addr", 32'(bank_addr_o), 32'd0);
    chk("starve_rd_be", 32'(bank_be_o), 32'hF);
    chk("starve_rvalid_prev", 32'(tcdm_rvalid_o), 32'd1);
    tick();
    scrub_en_i = 1'b0;
    #1;
    chk("starve_resp_rvalid", 32'(tcdm_rvalid_o), 32'd0);
    chk("starve_resp_gnt", 32'(tcdm_gnt_o), 32'd1);
    chk("starve_resp_addr", 32'(bank_addr_o), 32'h42);
    tick();
    chk("starve_rvalid_back", 32'(tcdm_rvalid_o), 32'd1);

    // Single-bit error at address 5 with enable dropped in RESP
    tick();
    tcdm_req_i = 1'b0; scrub_en_i = 1'b1;
    repeat (8) tick();
    tick();
    chk("se_rd_addr", 32'(bank_addr_o), 32'd5);
    chk("se_rd_req", 32'(bank_req_o), 32'd1);
    tick();
    bank_rdata_i = 32'hDEADBEEF; bank_err_single_i = 1'b1; scrub_en_i = 1'b0;
    tcdm_req_i = 1'b1; tcdm_wen_i = 1'b0; tcdm_add_i = 13'h0077;
    #1;
    chk("wb_req", 32'(bank_req_o), 32'd1);
    chk("wb_we", 32'(bank_we_o), 32'd1);
    chk("wb_addr", 32'(bank_addr_o), 32'd5);
    chk("wb_wdata", bank_wdata_o, 32'hDEADBEEF);
    chk("wb_be", 32'(bank_be_o), 32'hF);
    chk("wb_gnt", 32'(tcdm_gnt_o), 32'd0);
    tick();
    bank_err_single_i = 1'b0; tcdm_req_i = 1'b0; tcdm_wen_i = 1'b1;
    #1;
    chk("se_corr_cnt", 32'(corr_cnt_o), 32'd1);
    chk("se_ptr", 32'(scrub_addr_o), 32'd6);
    chk("se_scrub_cnt", 32'(scrub_cnt_o), 32'd8198);
    chk("se_rvalid", 32'(tcdm_rvalid_o), 32'd0);
    busy = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bank_req_o) busy++;
    end
    chk("se_then_idle", 32'(busy), 32'd0);

    // Multi-bit error: counted, no writeback, TCDM granted in RESP
    tick();
    scrub_en_i = 1'b1;
    tick();
    chk("me_rd_addr", 32'(bank_addr_o), 32'd6);
    tick();
    bank_rdata_i = 32'h0BADF00D; bank_err_multi_i = 1'b1; scrub_en_i = 1'b0;
    tcdm_req_i = 1'b1; tcdm_wen_i = 1'b1; tcdm_add_i = 13'h0099;
    #1;
    chk("me_gnt", 32'(tcdm_gnt_o), 32'd1);
    chk("me_we", 32'(bank_we_o), 32'd0);
    chk("me_addr", 32'(bank_addr_o), 32'h99);
    tick();
    bank_err_multi_i = 1'b0; tcdm_req_i = 1'b0;
    #1;
    chk("me_uncorr_cnt", 32'(uncorr_cnt_o), 32'd1);
    chk("me_corr_cnt", 32'(corr_cnt_o), 32'd1);
    chk("me_rvalid", 32'(tcdm_rvalid_o), 32'd1);

    // Reset during RESP with a single-bit error aborts the writeback
    tick();
    scrub_en_i = 1'b1;
    tick();
    chk("rr_rd_addr", 32'(bank_addr_o), 32'd7);
    tick();
    bank_err_single_i = 1'b1; rst_i = 1'b1; scrub_en_i = 1'b0;
    tcdm_req_i = 1'b1; tcdm_wen_i = 1'b1; tcdm_add_i = 13'h0033;
    #1;
    chk("rr_no_wb_we", 32'(bank_we_o), 32'd0);
    chk("rr_no_wb_addr", 32'(bank_addr_o), 32'h33);
    tick();
    rst_i = 1'b0; bank_err_single_i = 1'b0; tcdm_req_i = 1'b0;
    #1;
    chk("rr_scrub_cnt", 32'(scrub_cnt_o), 32'd0);
    chk("rr_corr_cnt", 32'(corr_cnt_o), 32'd0);
    chk("rr_uncorr_cnt", 32'(uncorr_cnt_o), 32'd0);
    chk("rr_ptr", 32'(scrub_addr_o), 32'd0);
    chk("rr_rvalid", 32'(tcdm_rvalid_o), 32'd0);
    chk("rr_sat_cnt", 32'(s_scnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
